// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan_n registered multiplexer.
// Holds the scan FSM states, the mode encodings and a lowest-set-bit search.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FIN
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_CH = 64;

    // Lowest set bit of mask at or above index 'from'; returns found, index via idx.
    function automatic logic next_set_bit(input logic [MAX_CH-1:0] mask,
                                          input int from,
                                          output int idx);
        logic found;
        found = 1'b0;
        idx   = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                found = 1'b1;
                idx   = i;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/mux_scan_prienc.sv
// Priority encoder: lowest set mask bit whose index is >= from.
// from=0 gives the first scan channel, from=ptr+1 gives the next one.
module mux_scan_prienc
    import mux_scan_pkg::*;
#(
    parameter int NCH = 8,
    parameter int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [SW:0]    from,
    output logic           found,
    output logic [SW-1:0]  idx
);

    int hit;

    always_comb begin
        hit   = 0;
        found = next_set_bit(MAX_CH'(mask), int'(from), hit);
        idx   = SW'(hit);
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel, DW-bit multiplexer with direct and scan modes,
// complementary outputs and a valid/ready output stream.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter int NCH = 8,
    parameter int DW  = 1,
    parameter int SW  = $clog2(NCH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH*DW-1:0] data,
    input  logic [SW-1:0]     select,
    input  logic              enb,
    input  logic              mode,
    input  logic [NCH-1:0]    chan_mask,
    input  logic              start,
    input  logic              ready,
    output logic [DW-1:0]     y,
    output logic [DW-1:0]     w,
    output logic [SW-1:0]     y_ch,
    output logic              valid,
    output logic              done
);

    logic [DW-1:0]  ch [NCH];
    state_t         state_reg;
    logic [SW-1:0]  ptr_reg;
    logic [NCH-1:0] mask_reg;
    logic [DW-1:0]  y_reg;
    logic [SW-1:0]  y_ch_reg;
    logic           valid_reg;
    logic           done_reg;

    logic [NCH-1:0] pe_mask;
    logic [SW:0]    pe_from;
    logic           pe_found;
    logic [SW-1:0]  pe_idx;
    logic [DW-1:0]  direct_y;
    logic           hold;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch[gi] = data[gi*DW +: DW];
        end
    endgenerate

    // In IDLE the encoder looks at the live mask for the first channel;
    // during a sweep it searches the captured mask above the current pointer.
    assign pe_mask = (state_reg == ST_IDLE) ? chan_mask : mask_reg;
    assign pe_from = (state_reg == ST_IDLE) ? '0 : ({1'b0, ptr_reg} + (SW+1)'(1));

    mux_scan_prienc #(
        .NCH (NCH),
        .SW  (SW)
    ) u_prienc (
        .mask  (pe_mask),
        .from  (pe_from),
        .found (pe_found),
        .idx   (pe_idx)
    );

    // Out-of-range selects (non-power-of-2 NCH) yield zero data.
    assign direct_y = ({1'b0, select} < (SW+1)'(NCH)) ? ch[select] : '0;
    assign hold     = valid_reg & ~ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            mask_reg  <= '0;
            y_reg     <= '0;
            y_ch_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else if (enb) begin
            state_reg <= ST_IDLE;
            y_reg     <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (mode == MODE_DIRECT) begin
                        if (!hold) begin
                            y_reg     <= direct_y;
                            y_ch_reg  <= select;
                            valid_reg <= 1'b1;
                        end
                    end else begin
                        valid_reg <= 1'b0;
                        if (start) begin
                            mask_reg <= chan_mask;
                            if (pe_found) begin
                                ptr_reg   <= pe_idx;
                                state_reg <= ST_SCAN;
                            end else begin
                                state_reg <= ST_FIN;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                end
                ST_SCAN: begin
                    if (!valid_reg) begin
                        y_reg     <= ch[ptr_reg];
                        y_ch_reg  <= ptr_reg;
                        valid_reg <= 1'b1;
                    end else if (ready) begin
                        // Accepted: load the next channel in the same edge.
                        if (pe_found) begin
                            ptr_reg  <= pe_idx;
                            y_reg    <= ch[pe_idx];
                            y_ch_reg <= pe_idx;
                        end else begin
                            valid_reg <= 1'b0;
                            state_reg <= ST_FIN;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign y     = y_reg;
    assign w     = ~y_reg;
    assign y_ch  = y_ch_reg;
    assign valid = valid_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: queue-based reference model compared
// every cycle, plus directed literal checks for reset, direct, stall, scan, abort.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic [2:0]  select;
    logic        enb;
    logic        mode;
    logic [7:0]  chan_mask;
    logic        start;
    logic        ready;

    logic [3:0]  y, w;
    logic [2:0]  y_ch;
    logic        valid, done;

    logic [3:0]  y6, w6;
    logic [2:0]  y_ch6;
    logic        valid6, done6;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mux_scan_n #(.NCH(8), .DW(4)) dut (
        .clock(clk), .reset(reset), .data(data), .select(select), .enb(enb),
        .mode(mode), .chan_mask(chan_mask), .start(start), .ready(ready),
        .y(y), .w(w), .y_ch(y_ch), .valid(valid), .done(done)
    );

    // Six-channel copy exercises out-of-range selects in direct mode.
    mux_scan_n #(.NCH(6), .DW(4)) dut6 (
        .clock(clk), .reset(reset), .data(data[23:0]), .select(select), .enb(enb),
        .mode(mode), .chan_mask(chan_mask[5:0]), .start(start), .ready(ready),
        .y(y6), .w(w6), .y_ch(y_ch6), .valid(valid6), .done(done6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: scan = a queue of masked channels drained one per accepted beat.
    logic [3:0] m_y, m_w;
    logic [2:0] m_ych;
    logic       m_valid, m_done, m_scan, m_fin;
    int         m_q[$];

    function automatic logic [3:0] chan_val(input int k);
        return data[k*4 +: 4];
    endfunction

    always @(posedge clk) begin : model
        if (reset) begin
            m_y = 4'h0; m_ych = 3'd0; m_valid = 1'b0; m_done = 1'b0;
            m_scan = 1'b0; m_fin = 1'b0; m_q.delete();
        end else if (enb) begin
            m_y = 4'h0; m_valid = 1'b0; m_done = 1'b0;
            m_scan = 1'b0; m_fin = 1'b0; m_q.delete();
        end else if (m_fin) begin
            m_fin = 1'b0; m_done = 1'b0;
        end else if (m_scan) begin
            if (!(m_valid && !ready)) begin
                if (m_valid) void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_valid = 1'b0; m_scan = 1'b0; m_fin = 1'b1; m_done = 1'b1;
                end else begin
                    m_ych = 3'(m_q[0]); m_y = chan_val(m_q[0]); m_valid = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (mode == 1'b0) begin
                if (!(m_valid && !ready)) begin
                    m_ych = select; m_y = chan_val(int'(select)); m_valid = 1'b1;
                end
            end else begin
                m_valid = 1'b0;
                if (start) begin
                    for (int k = 0; k < 8; k++) if (chan_mask[k]) m_q.push_back(k);
                    if (m_q.size() == 0) begin
                        m_fin = 1'b1; m_done = 1'b1;
                    end else begin
                        m_scan = 1'b1;
                    end
                end
            end
        end
        m_w = ~m_y;
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("model_y", 32'(y), 32'(m_y));
            chk("model_w", 32'(w), 32'(m_w));
            chk("model_y_ch", 32'(y_ch), 32'(m_ych));
            chk("model_valid", 32'(valid), 32'(m_valid));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end

    // Beats handed downstream (valid & ready at a clock edge).
    int xfer[$];
    always @(posedge clk) begin : recorder
        if (!reset && !enb && valid && ready) xfer.push_back(int'(y_ch));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int  exp_seq[4] = '{1, 2, 5, 7};
    bit  rp[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit  seen_done;

    initial begin
        reset = 1'b1; enb = 1'b1; data = '1; select = 3'd0; mode = 1'b0;
        chan_mask = 8'h00; start = 1'b0; ready = 1'b1;
        step(2);
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_w", 32'(w), 32'hF);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_y_ch", 32'(y_ch), 32'h0);
        reset = 1'b0;
        cmp_en = 1'b1;
        step(2);
        chk("dis_y", 32'(y), 32'h0);
        chk("dis_w", 32'(w), 32'hF);
        chk("dis_valid", 32'(valid), 32'h0);

        // Direct sweep: only channel 2 carries a one.
        enb = 1'b0; data = 32'h0000_0100;
        for (int s = 0; s < 8; s++) begin
            select = 3'(s);
            step(1);
            chk("sweep_y", 32'(y), (s == 2) ? 32'h1 : 32'h0);
            chk("sweep_y_ch", 32'(y_ch), 32'(s));
            chk("sweep6_y", 32'(y6), (s == 2) ? 32'h1 : 32'h0);
        end
        chk("sel_oob_y", 32'(y6), 32'h0);
        chk("sel_oob_y_ch", 32'(y_ch6), 32'h7);
        chk("sel_oob_valid", 32'(valid6), 32'h1);

        // Direct stall: y holds while ready is low.
        data = 32'h00A0_0000; select = 3'd5;
        step(1);
        chk("stall_load", 32'(y), 32'hA);
        ready = 1'b0; data = 32'h0030_0000;
        step(2);
        chk("stall_hold", 32'(y), 32'hA);
        chk("stall_valid", 32'(valid), 32'h1);
        ready = 1'b1;
        step(1);
        chk("stall_release", 32'(y), 32'h3);

        // Scan with mask 1010_0110; channel k carries 8+k.
        data = 32'hFEDC_BA98; mode = 1'b1; chan_mask = 8'hA6; start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("scan_y_ch", 32'(y_ch), 32'(exp_seq[i]));
            chk("scan_y", 32'(y), 32'(8 + exp_seq[i]));
            chk("scan_valid", 32'(valid), 32'h1);
        end
        step(1);
        chk("scan_done", 32'(done), 32'h1);
        chk("scan_end_valid", 32'(valid), 32'h0);
        step(1);
        chk("scan_done_pulse", 32'(done), 32'h0);

        // Scan under backpressure: each channel delivered exactly once.
        xfer.delete();
        seen_done = 1'b0;
        start = 1'b1; ready = rp[0];
        step(1);
        start = 1'b0;
        for (int i = 1; i < 16 && !seen_done; i++) begin
            ready = rp[i];
            step(1);
            if (done) seen_done = 1'b1;
        end
        chk("bp_done_seen", 32'(seen_done), 32'h1);
        chk("bp_xfer_count", 32'(xfer.size()), 32'h4);
        for (int i = 0; i < 4; i++)
            chk("bp_xfer_ch", (i < xfer.size()) ? 32'(xfer[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
        ready = 1'b1;
        step(1);

        // Empty mask: done pulses, no beat.
        chan_mask = 8'h00; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("empty_done", 32'(done), 32'h1);
        chk("empty_valid", 32'(valid), 32'h0);
        step(1);
        chk("empty_done_pulse", 32'(done), 32'h0);
        chk("empty_valid2", 32'(valid), 32'h0);

        // Abort at channel 2, then restart from channel 1.
        chan_mask = 8'hA6; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("abort_pre_y_ch", 32'(y_ch), 32'h2);
        enb = 1'b1;
        step(1);
        chk("abort_y", 32'(y), 32'h0);
        chk("abort_valid", 32'(valid), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        step(2);
        enb = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        chk("restart_y_ch", 32'(y_ch), 32'h1);
        chk("restart_valid", 32'(valid), 32'h1);
        step(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
